// File: rtl/matmul_pkg.sv
// -----------------------------------------------------------------------------
// matmul_pkg
// Shared constants and types for the 4x4 8-bit matrix-multiply stream path.
// Used by matmul_stream_ctrl, its result serializer and the core_b wrappers.
//   N         matrix dimension
//   ELEM_W    operand element width
//   RES_W     result element width
//   IN_BYTES  operand bytes per job (A then B, row-major)
//   NUM_RES   result words per job
// -----------------------------------------------------------------------------
package matmul_pkg;

    localparam int N        = 4;
    localparam int ELEM_W   = 8;
    localparam int RES_W    = 16;
    localparam int NUM_RES  = N * N;
    localparam int IN_BYTES = 2 * NUM_RES;

    // Flat bus widths between this block and the core
    localparam int OPND_W   = NUM_RES * ELEM_W;    // a_flat / b_flat
    localparam int RESB_W   = NUM_RES * RES_W;     // c_flat

    // Counter widths
    localparam int K_W      = $clog2(IN_BYTES);    // input byte counter
    localparam int IDX_W    = $clog2(NUM_RES);     // output word index

    typedef enum logic [1:0] {
        LOAD,
        CALC,
        DRAIN
    } state_e;

endpackage

// File: rtl/matmul_stream_ctrl_if.sv
// -----------------------------------------------------------------------------
// matmul_stream_ctrl_if
// Valid/ready byte stream in, valid/ready result-word stream out.
//   in_valid / in_ready / in_data      operand bytes toward the controller
//   out_valid / out_ready / out_data   result words from the controller
//   out_last                           marks the 16th word of a job
// Modports:
//   master  stream fabric side (drives bytes, consumes words)
//   slave   controller side
// -----------------------------------------------------------------------------
interface matmul_stream_ctrl_if;
    import matmul_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [ELEM_W-1:0] in_data;

    logic              out_valid;
    logic              out_ready;
    logic [RES_W-1:0]  out_data;
    logic              out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

endinterface

// File: rtl/matmul_result_ser.sv
// -----------------------------------------------------------------------------
// matmul_result_ser
// Captures the core's flat result bus in one cycle and streams the 16 result
// words out in row-major order over valid/ready.
//   clk, rst    clock, asynchronous active-high reset
//   capture     one-cycle pulse: latch c_flat and start streaming
//   c_flat      flat result bus from the core
//   out_ready   downstream accept
//   out_valid   result word valid (registered)
//   out_data    current word, decoded from registered res_q/idx
//   out_last    high with word 15
//   done        handshake on word 15 this cycle (tells the FSM to reload)
// -----------------------------------------------------------------------------
module matmul_result_ser
    import matmul_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              capture,
    input  logic [RESB_W-1:0] c_flat,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [RES_W-1:0]  out_data,
    output logic              out_last,
    output logic              done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RES - 1);

    logic [RESB_W-1:0] res_q;
    logic [IDX_W-1:0]  idx_q;
    logic              hs;

    assign hs   = out_valid && out_ready;
    assign done = hs && (idx_q == LAST_IDX);

    // NOTE: res_q is a plain wide register, not a RAM, so it can take the
    // async reset; that is what makes out_data read zero straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q     <= '0;
            idx_q     <= '0;
            out_valid <= 1'b0;
        end else if (capture) begin
            res_q     <= c_flat;
            idx_q     <= '0;
            out_valid <= 1'b1;
        end else if (hs) begin
            if (idx_q == LAST_IDX) begin
                idx_q     <= '0;
                out_valid <= 1'b0;
            end else begin
                idx_q     <= idx_q + 1'b1;
            end
        end
    end

    // Pure decode of registered state: holds steady under backpressure.
    assign out_data = res_q[idx_q*RES_W +: RES_W];
    assign out_last = out_valid && (idx_q == LAST_IDX);

endmodule

// File: rtl/matmul_stream_ctrl.sv
// -----------------------------------------------------------------------------
// matmul_stream_ctrl
// Streaming front/back end for the combinational 4x4 matrix-multiply core.
// Assembles A and B from 32 input bytes, holds them on a_flat/b_flat for the
// core, captures c_flat one cycle later, then drains 16 result words.
//   clk, rst    clock, asynchronous active-high reset
//   strm        valid/ready byte input and result-word output (slave modport)
//   a_flat      operand A to core, element (i,j) at [(i*4+j)*8 +: 8]
//   b_flat      operand B to core, same layout
//   c_flat      result from core, element (i,j) at [(i*4+j)*16 +: 16]
//   busy        high in CALC and DRAIN
// -----------------------------------------------------------------------------
module matmul_stream_ctrl
    import matmul_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    matmul_stream_ctrl_if.slave  strm,
    output logic [OPND_W-1:0]    a_flat,
    output logic [OPND_W-1:0]    b_flat,
    input  logic [RESB_W-1:0]    c_flat,
    output logic                 busy
);

    localparam logic [K_W-1:0] LAST_K = K_W'(IN_BYTES - 1);

    state_e         state_q;
    logic [K_W-1:0] k_q;
    logic           in_ready_q;
    logic           busy_q;
    logic           accept;
    logic           drain_done;

    assign accept = strm.in_valid && in_ready_q;

    // NOTE: all state below updates with <= so every register samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= LOAD;
            k_q        <= '0;
            a_flat     <= '0;
            b_flat     <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (accept) begin
                        // MSB of k selects the matrix, low bits the element.
                        if (!k_q[K_W-1])
                            a_flat[k_q[K_W-2:0]*ELEM_W +: ELEM_W] <= strm.in_data;
                        else
                            b_flat[k_q[K_W-2:0]*ELEM_W +: ELEM_W] <= strm.in_data;

                        if (k_q == LAST_K) begin
                            k_q        <= '0;
                            state_q    <= CALC;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                        end else begin
                            k_q <= k_q + 1'b1;
                        end
                    end
                end

                // Operands are stable all cycle; the serializer latches c_flat
                // at the end of it.
                CALC: state_q <= DRAIN;

                DRAIN: begin
                    if (drain_done) begin
                        state_q    <= LOAD;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end
                end

                default: begin
                    state_q    <= LOAD;
                    k_q        <= '0;
                    in_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign strm.in_ready = in_ready_q;
    assign busy          = busy_q;

    matmul_result_ser u_result_ser (
        .clk       (clk),
        .rst       (rst),
        .capture   (state_q == CALC),
        .c_flat    (c_flat),
        .out_ready (strm.out_ready),
        .out_valid (strm.out_valid),
        .out_data  (strm.out_data),
        .out_last  (strm.out_last),
        .done      (drain_done)
    );

endmodule

// File: tb/tb_matmul_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_matmul_stream_ctrl
// Directed bench for matmul_stream_ctrl with a behavioural 4x4 core stand-in
// on a_flat/b_flat -> c_flat. Jobs are table entries with hand-computed
// expected result words plus per-job stimulus modes (input gaps, output
// stalls, 0xAA held on the input during CALC/DRAIN).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_matmul_stream_ctrl;
    import matmul_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    matmul_stream_ctrl_if bus ();

    logic [OPND_W-1:0] a_flat;
    logic [OPND_W-1:0] b_flat;
    logic [RESB_W-1:0] c_flat;
    logic              busy;

    matmul_stream_ctrl dut (
        .clk    (clk),
        .rst    (rst),
        .strm   (bus),
        .a_flat (a_flat),
        .b_flat (b_flat),
        .c_flat (c_flat),
        .busy   (busy)
    );

    // Combinational core stand-in: C = A x B, sums modulo 2^16.
    function automatic logic [RESB_W-1:0] core_mul(input logic [OPND_W-1:0] a,
                                                   input logic [OPND_W-1:0] b);
        logic [RESB_W-1:0] c;
        logic [RES_W-1:0]  acc;
        c = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                acc = '0;
                for (int k = 0; k < N; k++)
                    acc = acc + RES_W'(a[(i*N+k)*ELEM_W +: ELEM_W]) *
                                RES_W'(b[(k*N+j)*ELEM_W +: ELEM_W]);
                c[(i*N+j)*RES_W +: RES_W] = acc;
            end
        end
        return c;
    endfunction

    assign c_flat = core_mul(a_flat, b_flat);

    // ------------------------------------------------------------------ checks
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------- job table
    typedef struct {
        logic [7:0]  a   [16];
        logic [7:0]  b   [16];
        logic [15:0] exp [16];
        bit          gaps;   // in_valid low every third byte slot
        bit          stall;  // out_ready pattern 1,0,0,1
        bit          hold;   // in_valid=1, in_data=0xAA during CALC/DRAIN
    } job_t;

    job_t jobs [5];

    function automatic logic [OPND_W-1:0] pack_job(input int j, input bit sel_b);
        logic [OPND_W-1:0] p;
        p = '0;
        for (int n = 0; n < NUM_RES; n++)
            p[n*ELEM_W +: ELEM_W] = sel_b ? jobs[j].b[n] : jobs[j].a[n];
        return p;
    endfunction

    task automatic fill_jobs();
        for (int n = 0; n < 16; n++) begin
            // 0: A = I, B(i,j) = i*4+j+1 -> words 1..16
            jobs[0].a[n]   = (n / 4 == n % 4) ? 8'h01 : 8'h00;
            jobs[0].b[n]   = 8'(n + 1);
            jobs[0].exp[n] = 16'(n + 1);
            // 1: all 0xFF -> 4*255*255 mod 2^16 = 0xF804
            jobs[1].a[n]   = 8'hFF;
            jobs[1].b[n]   = 8'hFF;
            jobs[1].exp[n] = 16'hF804;
            // 2: A all 1, B all 2 -> 4*2 = 8
            jobs[2].a[n]   = 8'h01;
            jobs[2].b[n]   = 8'h02;
            jobs[2].exp[n] = 16'h0008;
            // 3: A = diag(1,2,3,4), B all 0x10 -> row i = (i+1)*0x10
            jobs[3].a[n]   = (n / 4 == n % 4) ? 8'(n / 4 + 1) : 8'h00;
            jobs[3].b[n]   = 8'h10;
            jobs[3].exp[n] = 16'((n / 4 + 1) * 16);
            // 4: A = 2*I, B all 3 -> 6
            jobs[4].a[n]   = (n / 4 == n % 4) ? 8'h02 : 8'h00;
            jobs[4].b[n]   = 8'h03;
            jobs[4].exp[n] = 16'h0006;
        end
        jobs[0].gaps = 0; jobs[0].stall = 0; jobs[0].hold = 0;
        jobs[1].gaps = 0; jobs[1].stall = 1; jobs[1].hold = 0;
        jobs[2].gaps = 1; jobs[2].stall = 0; jobs[2].hold = 1;
        jobs[3].gaps = 1; jobs[3].stall = 1; jobs[3].hold = 1;
        jobs[4].gaps = 0; jobs[4].stall = 1; jobs[4].hold = 0;
    endtask

    // ----------------------------------------------------------------- tasks
    // All driving and sampling happens right after the falling edge.
    task automatic load_job(input int j, input int nbytes);
        for (int n = 0; n < nbytes; n++) begin
            if (jobs[j].gaps && (n % 3 == 2)) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'hAA;
                @(negedge clk);
            end
            bus.in_valid = 1'b1;
            if (n < 16) bus.in_data = jobs[j].a[n];
            else        bus.in_data = jobs[j].b[n-16];
            check($sformatf("job%0d_in_ready_b%0d", j, n), bus.in_ready, 1'b1);
            @(negedge clk);
        end
        bus.in_valid = jobs[j].hold;
        bus.in_data  = 8'hAA;
    endtask

    task automatic drain_job(input int j, input int nwords);
        int         cnt = 0;
        int         cyc = 0;
        logic [3:0] pat = 4'b1001;  // bit order 0..3 gives 1,0,0,1
        while (cnt < nwords && cyc < 200) begin
            bus.out_ready = jobs[j].stall ? pat[cyc % 4] : 1'b1;
            check($sformatf("job%0d_valid_w%0d", j, cnt), bus.out_valid, 1'b1);
            check($sformatf("job%0d_data_w%0d", j, cnt), bus.out_data, jobs[j].exp[cnt]);
            check($sformatf("job%0d_last_w%0d", j, cnt), bus.out_last, cnt == 15);
            check($sformatf("job%0d_drain_in_ready_w%0d", j, cnt), bus.in_ready, 1'b0);
            if (bus.out_valid && bus.out_ready) cnt++;
            @(negedge clk);
            cyc++;
        end
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check($sformatf("job%0d_handshakes", j), cnt, nwords);
    endtask

    task automatic run_job(input int j);
        load_job(j, IN_BYTES);
        check($sformatf("job%0d_calc_in_ready", j), bus.in_ready, 1'b0);
        check($sformatf("job%0d_calc_busy", j), busy, 1'b1);
        check($sformatf("job%0d_calc_out_valid", j), bus.out_valid, 1'b0);
        @(negedge clk);
        check($sformatf("job%0d_first_word_valid", j), bus.out_valid, 1'b1);
        drain_job(j, NUM_RES);
        check($sformatf("job%0d_end_out_valid", j), bus.out_valid, 1'b0);
        check($sformatf("job%0d_end_busy", j), busy, 1'b0);
        check($sformatf("job%0d_end_in_ready", j), bus.in_ready, 1'b1);
        check($sformatf("job%0d_a_flat_hold", j), a_flat, pack_job(j, 1'b0));
        check($sformatf("job%0d_b_flat_hold", j), b_flat, pack_job(j, 1'b1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  bus.in_ready,  1'b1);
        check({tag, "_out_valid"}, bus.out_valid, 1'b0);
        check({tag, "_out_data"},  bus.out_data,  16'h0000);
        check({tag, "_out_last"},  bus.out_last,  1'b0);
        check({tag, "_busy"},      busy,          1'b0);
        check({tag, "_a_flat"},    a_flat,        '0);
        check({tag, "_b_flat"},    b_flat,        '0);
    endtask

    // --------------------------------------------------------------- stimulus
    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;
        fill_jobs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");

        // Table: identity, wrap+stall, gaps+masking, all modes combined
        for (int j = 0; j < 4; j++)
            run_job(j);

        // Reset after 20 bytes of a job, then a fresh full job
        load_job(1, 20);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid_load");
        @(negedge clk);
        rst = 1'b0;
        run_job(4);

        // Reset after 5 drained words; async clear of out_valid
        load_job(0, IN_BYTES);
        @(negedge clk);
        drain_job(0, 5);
        check("rst_mid_drain_pre_valid", bus.out_valid, 1'b1);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid_drain");
        @(negedge clk);
        rst = 1'b0;
        run_job(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
